// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: detects load-use, taken branch,
// SRAM wait-state and interrupt-entry hazards and drives per-stage enable/flush controls.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr_ID,
  input  logic [31:0]      i_instr_EX,
  input  logic             i_mem_rden_EX,
  input  logic             i_br_taken_EX,
  input  logic             i_mem_req_MEM,
  input  logic             i_mem_ack,
  input  logic             i_irq_req,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_flush,
  output logic             o_irq_ack,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int unsigned TO_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_S     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_B     = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_IRQ_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                 id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
                                 mem_wb_flush: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
                                    mem_wb_flush: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                   id_ex_en: 1'b0, id_ex_flush: 1'b1, ex_mem_en: 1'b0,
                                   mem_wb_flush: 1'b1};

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_nxt;
  logic              to_hit;
  logic              irq_take;
  logic              irq_armed;
  logic              irq_ack_q;
  logic              mem_to_q;
  logic [CNT_W-1:0]  stall_cnt;

  logic [OPC_W-1:0]  opc_id;
  logic [REG_W-1:0]  rd_ex;
  logic [REG_W-1:0]  rs1_id;
  logic [REG_W-1:0]  rs2_id;
  logic              use_rs1;
  logic              use_rs2;
  logic              load_use;
  logic              mem_busy;
  logic              unused_instr_bits;

  // Operand-use decode and load-use detection
  always_comb begin
    opc_id   = i_instr_ID[6:0];
    rd_ex    = i_instr_EX[11:7];
    rs1_id   = i_instr_ID[19:15];
    rs2_id   = i_instr_ID[24:20];
    use_rs1  = !((opc_id == OPC_LUI) || (opc_id == OPC_AUIPC) || (opc_id == OPC_JAL));
    use_rs2  = (opc_id == OPC_R) || (opc_id == OPC_S) || (opc_id == OPC_B);
    load_use = i_mem_rden_EX && (rd_ex != '0) &&
               ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));
    mem_busy = i_mem_req_MEM && !i_mem_ack;
  end

  assign unused_instr_bits = ^{i_instr_ID[31:25], i_instr_ID[14:7],
                               i_instr_EX[31:12], i_instr_EX[6:0]};

  // Next-state and stage controls
  always_comb begin
    state_nxt  = state;
    ctrl       = CTRL_RUN;
    to_cnt_nxt = '0;
    to_hit     = 1'b0;
    irq_take   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEM_WAIT;
        end else if (i_irq_req && irq_armed) begin
          irq_take  = 1'b1;
          state_nxt = ST_IRQ_FLUSH;
        end else if (i_br_taken_EX) begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ack) begin
          state_nxt = ST_RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if ((MEM_TIMEOUT != 0) && (to_cnt == TO_W'(MEM_TIMEOUT - 1))) begin
            to_hit    = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
          end
        end
      end
      ST_IRQ_FLUSH: begin
        // A pending SRAM access outranks the interrupt flush; the ack is already registered
        if (mem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEM_WAIT;
        end else begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          state_nxt        = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (i_reset) begin
      ctrl = CTRL_RESET;
    end
  end

  // State, timeout counter, interrupt arming, pulses and stall statistics
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_RUN;
      to_cnt    <= '0;
      irq_armed <= 1'b1;
      irq_ack_q <= 1'b0;
      mem_to_q  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_cnt_nxt;
      irq_ack_q <= irq_take;
      mem_to_q  <= to_hit;
      if (irq_take) begin
        irq_armed <= 1'b0;
      end else if (!i_irq_req) begin
        irq_armed <= 1'b1;
      end
      if (!ctrl.pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pc_en        = ctrl.pc_en;
  assign o_if_id_en     = ctrl.if_id_en;
  assign o_if_id_flush  = ctrl.if_id_flush;
  assign o_id_ex_en     = ctrl.id_ex_en;
  assign o_id_ex_flush  = ctrl.id_ex_flush;
  assign o_ex_mem_en    = ctrl.ex_mem_en;
  assign o_mem_wb_flush = ctrl.mem_wb_flush;
  assign o_irq_ack      = irq_ack_q;
  assign o_mem_timeout  = mem_to_q;
  assign o_stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model built from the hazard priority rules.
module tb_hazard_stall_ctrl;

  localparam int TO = 16;

  // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_FLUSH  = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_RESET  = 7'b0010101;

  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADD_X6 = 32'h00728333;
  localparam logic [31:0] ADD_X0 = 32'h00000333;
  localparam logic [31:0] LUI_X6 = 32'h00028337;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_id, instr_ex;
  logic        mem_rden_ex, br_taken_ex, mem_req_mem, mem_ack, irq_req;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic        irq_ack, mem_timeout;
  logic [15:0] stall_cnt;
  logic [6:0]  ctl;

  int errors = 0;
  int checks = 0;
  int stall_exp = 0;

  // Behavioural model state
  bit m_waiting, m_flush_due, m_armed, m_ack, m_to;
  int m_wait_cycles, m_cnt;

  always #5 clk = ~clk;

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_instr_ID(instr_id), .i_instr_EX(instr_ex),
    .i_mem_rden_EX(mem_rden_ex), .i_br_taken_EX(br_taken_ex), .i_mem_req_MEM(mem_req_mem),
    .i_mem_ack(mem_ack), .i_irq_req(irq_req), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
    .o_if_id_flush(if_id_flush), .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_flush),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_flush(mem_wb_flush), .o_irq_ack(irq_ack),
    .o_mem_timeout(mem_timeout), .o_stall_cnt(stall_cnt)
  );

  task automatic clr_in();
    reset = 1'b0; instr_id = NOP; instr_ex = NOP; mem_rden_ex = 1'b0;
    br_taken_ex = 1'b0; mem_req_mem = 1'b0; mem_ack = 1'b0; irq_req = 1'b0;
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1-2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit lu_ref(logic [31:0] id, logic [31:0] ex, logic rden);
    logic [6:0] op = id[6:0];
    bit r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    bit r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    return rden && (ex[11:7] != 5'd0) &&
           ((r1 && id[19:15] == ex[11:7]) || (r2 && id[24:20] == ex[11:7]));
  endfunction

  function automatic logic [6:0] model_ctl();
    bit busy = mem_req_mem && !mem_ack;
    if (reset) return C_RESET;
    if (m_waiting) return mem_ack ? C_RUN : C_FREEZE;
    if (m_flush_due) return busy ? C_FREEZE : C_FLUSH;
    if (busy) return C_FREEZE;
    if (irq_req && m_armed) return C_RUN;
    if (br_taken_ex) return C_FLUSH;
    if (lu_ref(instr_id, instr_ex, mem_rden_ex)) return C_LU;
    return C_RUN;
  endfunction

  task automatic model_advance(input logic exp_pc_en);
    bit busy = mem_req_mem && !mem_ack;
    bit ack_n = 0, to_n = 0;
    if (reset) begin
      m_waiting = 0; m_flush_due = 0; m_armed = 1; m_cnt = 0; m_wait_cycles = 0;
      m_ack = 0; m_to = 0;
      return;
    end
    if (!exp_pc_en && m_cnt < 65535) m_cnt++;
    if (m_waiting) begin
      if (mem_ack) m_waiting = 0;
      else if (m_wait_cycles + 1 == TO) begin m_waiting = 0; to_n = 1; end
      else m_wait_cycles++;
    end else if (m_flush_due) begin
      m_flush_due = 0;
      if (busy) begin m_waiting = 1; m_wait_cycles = 0; end
    end else if (busy) begin
      m_waiting = 1; m_wait_cycles = 0;
    end else if (irq_req && m_armed) begin
      m_flush_due = 1; ack_n = 1; m_armed = 0;
    end
    if (!irq_req) m_armed = 1;
    m_ack = ack_n;
    m_to = to_n;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL reset_run_ctl: got %b want %b", ctl, C_RUN); end
    checks++;
    if (stall_cnt !== 16'd0 || irq_ack !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: cnt=%0d ack=%b to=%b want 0 0 0", stall_cnt, irq_ack, mem_timeout);
    end
    stall_exp = 0;
    tick();
  endtask

  task automatic test_load_use();
    instr_ex = LW_X5; mem_rden_ex = 1'b1; instr_id = ADD_X6;
    #1;
    checks++;
    if (ctl !== C_LU) begin errors++; $display("FAIL load_use_ctl: got %b want %b", ctl, C_LU); end
    stall_exp++;
    tick();
    instr_ex = NOP; mem_rden_ex = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL load_use_release: got %b want %b", ctl, C_RUN); end
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      errors++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, stall_exp);
    end
    tick();
  endtask

  task automatic test_no_false_stall();
    instr_ex = LW_X5; mem_rden_ex = 1'b1; instr_id = LUI_X6;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL no_stall_lui: got %b want %b", ctl, C_RUN); end
    tick();
    instr_ex = LW_X0; instr_id = ADD_X0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL no_stall_x0: got %b want %b", ctl, C_RUN); end
    tick();
    clr_in();
  endtask

  task automatic test_branch();
    instr_ex = LW_X5; mem_rden_ex = 1'b1; instr_id = ADD_X6; br_taken_ex = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin errors++; $display("FAIL branch_ctl: got %b want %b", ctl, C_FLUSH); end
    tick();
    clr_in();
  endtask

  task automatic test_mem_wait();
    mem_req_mem = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL mem_wait_freeze%0d: got %b want %b", k, ctl, C_FREEZE);
      end
      stall_exp++;
      tick();
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL mem_wait_ack: got %b want %b", ctl, C_RUN); end
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      errors++; $display("FAIL mem_wait_cnt: got %0d want %0d", stall_cnt, stall_exp);
    end
    tick();
    clr_in();
    #1;
    checks++;
    if (ctl !== C_RUN || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL mem_wait_after: ctl=%b to=%b want %b 0", ctl, mem_timeout, C_RUN);
    end
    tick();
  endtask

  task automatic test_timeout();
    mem_req_mem = 1'b1;
    for (int k = 0; k <= TO; k++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE || mem_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d: ctl=%b to=%b want %b 0", k, ctl, mem_timeout, C_FREEZE);
      end
      stall_exp++;
      tick();
    end
    mem_req_mem = 1'b0;
    #1;
    checks++;
    if (mem_timeout !== 1'b1 || ctl !== C_RUN) begin
      errors++; $display("FAIL timeout_pulse: to=%b ctl=%b want 1 %b", mem_timeout, ctl, C_RUN);
    end
    tick();
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b want 0", mem_timeout); end
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      errors++; $display("FAIL timeout_cnt: got %0d want %0d", stall_cnt, stall_exp);
    end
  endtask

  task automatic test_irq();
    int acks = 0;
    irq_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (irq_ack === 1'b1) acks++;
      checks++;
      if (irq_ack !== (k == 1) || ctl !== ((k == 1) ? C_FLUSH : C_RUN)) begin
        errors++;
        $display("FAIL irq_held%0d: ack=%b ctl=%b want %b %b", k, irq_ack, ctl, (k == 1),
                 (k == 1) ? C_FLUSH : C_RUN);
      end
      tick();
    end
    irq_req = 1'b0;
    #1;
    checks++;
    if (acks != 1 || irq_ack !== 1'b0) begin
      errors++; $display("FAIL irq_ack_count: got %0d acks now=%b want 1 0", acks, irq_ack);
    end
    tick();
  endtask

  task automatic test_irq_during_wait();
    mem_req_mem = 1'b1;
    #1;
    stall_exp++;
    tick();
    irq_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (ctl !== C_FREEZE || irq_ack !== 1'b0) begin
        errors++; $display("FAIL irq_wait%0d: ctl=%b ack=%b want %b 0", k, ctl, irq_ack, C_FREEZE);
      end
      stall_exp++;
      tick();
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RUN || irq_ack !== 1'b0) begin
      errors++; $display("FAIL irq_wait_ack: ctl=%b ack=%b want %b 0", ctl, irq_ack, C_RUN);
    end
    tick();
    mem_req_mem = 1'b0; mem_ack = 1'b0;
    #1;
    checks++;
    if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_wait_early: ack=%b want 0", irq_ack); end
    tick();
    #1;
    checks++;
    if (irq_ack !== 1'b1 || ctl !== C_FLUSH) begin
      errors++; $display("FAIL irq_wait_taken: ack=%b ctl=%b want 1 %b", irq_ack, ctl, C_FLUSH);
    end
    tick();
    irq_req = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      errors++; $display("FAIL irq_wait_cnt: got %0d want %0d", stall_cnt, stall_exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    clr_in();
    mem_req_mem = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL mid_reset_ctl: got %b want %b", ctl, C_RESET); end
    tick();
    reset = 1'b0; mem_req_mem = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN || stall_cnt !== 16'd0 || irq_ack !== 1'b0 || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_after: ctl=%b cnt=%0d ack=%b to=%b want %b 0 0 0",
               ctl, stall_cnt, irq_ack, mem_timeout, C_RUN);
    end
    for (int k = 0; k < TO + 2; k++) begin
      tick();
      checks++;
      if (mem_timeout !== 1'b0 || irq_ack !== 1'b0) begin
        errors++; $display("FAIL mid_reset_pulse%0d: to=%b ack=%b want 0 0", k, mem_timeout, irq_ack);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    logic [6:0] exp;
    logic [31:0] w;
    clr_in();
    reset = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (n > 0) begin
        reset = ($urandom_range(0, 79) == 0);
        w = $urandom;
        instr_id = {w[31:25], 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), w[14:7],
                    ops[$urandom_range(0, 8)]};
        w = $urandom;
        instr_ex = {w[31:12], 5'($urandom_range(0, 3)), w[6:0]};
        mem_rden_ex = 1'($urandom_range(0, 1));
        br_taken_ex = ($urandom_range(0, 5) == 0);
        mem_req_mem = m_waiting ? 1'b1 : ($urandom_range(0, 5) == 0);
        mem_ack = (n < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
        irq_req = ($urandom_range(0, 3) == 0) ? ~irq_req : irq_req;
      end
      #1;
      exp = model_ctl();
      checks++;
      if (ctl !== exp) begin errors++; $display("FAIL rand_ctl@%0d: got %b want %b", n, ctl, exp); end
      checks++;
      if (irq_ack !== m_ack) begin errors++; $display("FAIL rand_ack@%0d: got %b want %b", n, irq_ack, m_ack); end
      checks++;
      if (mem_timeout !== m_to) begin
        errors++; $display("FAIL rand_timeout@%0d: got %b want %b", n, mem_timeout, m_to);
      end
      checks++;
      if (stall_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt@%0d: got %0d want %0d", n, stall_cnt, m_cnt);
      end
      model_advance(exp[6]);
      tick();
    end
    clr_in();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_irq();
    test_irq_during_wait();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
